// File: rtl/rsa_pkg.sv
// Shared constants and types for the modular exponentiation sequencer.
// Holds the state encoding, default RAM addresses and op-type codes.
package rsa_pkg;

    localparam int XBAR_ADDR_DEF = 0;
    localparam int MBAR_ADDR_DEF = 2;
    localparam int ONE_ADDR_DEF  = 4;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_SQ        = 4'd1;
    localparam logic [3:0] ST_WAIT_SQ   = 4'd2;
    localparam logic [3:0] ST_MUL       = 4'd3;
    localparam logic [3:0] ST_WAIT_MUL  = 4'd4;
    localparam logic [3:0] ST_NEXT      = 4'd5;
    localparam logic [3:0] ST_CONV      = 4'd6;
    localparam logic [3:0] ST_WAIT_CONV = 4'd7;
    localparam logic [3:0] ST_DONE      = 4'd8;

    typedef enum logic [3:0] {
        IDLE      = ST_IDLE,
        SQ        = ST_SQ,
        WAIT_SQ   = ST_WAIT_SQ,
        MUL       = ST_MUL,
        WAIT_MUL  = ST_WAIT_MUL,
        NEXT      = ST_NEXT,
        CONV      = ST_CONV,
        WAIT_CONV = ST_WAIT_CONV,
        DONE      = ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_SQ   = 2'd0,
        OP_MUL  = 2'd1,
        OP_CONV = 2'd2
    } op_e;

endpackage

// File: rtl/exp_bit_iter.sv
// Exponent bit iterator: loads e and the top bit index, walks downwards.
// Ports: clk, rst, load, step, e, e_idx in; cur_bit, last out.
module exp_bit_iter #(
    parameter int N     = 32,
    parameter int Nlog2 = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [N-1:0]     e,
    input  logic [Nlog2-1:0] e_idx,
    output logic             cur_bit,
    output logic             last
);

    logic [N-1:0]     e_q, e_d;
    logic [Nlog2-1:0] idx_q, idx_d;

    always_comb begin
        e_d   = e_q;
        idx_d = idx_q;
        if (load) begin
            e_d = e;
            // An index past the top exponent bit starts at the top bit.
            if (int'(e_idx) >= N) begin
                idx_d = Nlog2'(N - 1);
            end else begin
                idx_d = e_idx;
            end
        end else if (step && (idx_q != '0)) begin
            idx_d = idx_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q   <= '0;
            idx_q <= '0;
        end else begin
            e_q   <= e_d;
            idx_q <= idx_d;
        end
    end

    assign cur_bit = e_q[idx_q];
    assign last    = (idx_q == '0);

endmodule

// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply scheduler for the Montgomery unit.
// Ports: clk, rst, start, e, e_idx, mp_count, mp_done in;
//        mp_start, mp_a/b/r_addr, mp_len, busy, done, op_count out.
// Optional final conversion out of Montgomery form: FINAL_CONVERT_EN.
module modexp_sequencer
    import rsa_pkg::*;
#(
    parameter int N         = 32,
    parameter int Nlog2     = 5,
    parameter int ABITS     = 8,
    parameter int XBAR_ADDR = XBAR_ADDR_DEF,
    parameter int MBAR_ADDR = MBAR_ADDR_DEF,
    parameter int ONE_ADDR  = ONE_ADDR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     e,
    input  logic [Nlog2-1:0] e_idx,
    input  logic [Nlog2-1:0] mp_count,
    output logic             mp_start,
    output logic [ABITS-1:0] mp_a_addr,
    output logic [ABITS-1:0] mp_b_addr,
    output logic [ABITS-1:0] mp_r_addr,
    output logic [Nlog2-1:0] mp_len,
    input  logic             mp_done,
    output logic             busy,
    output logic             done,
    output logic [Nlog2+1:0] op_count
);

    state_e           state_q, state_d;
    logic             mp_start_q, mp_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [ABITS-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic [Nlog2-1:0] len_q, len_d;
    logic [Nlog2+1:0] cnt_q, cnt_d;

    logic load, step, issue, cur_bit, last;
    op_e  op;

    exp_bit_iter #(.N(N), .Nlog2(Nlog2)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .e       (e),
        .e_idx   (e_idx),
        .cur_bit (cur_bit),
        .last    (last)
    );

    always_comb begin
        state_d    = state_q;
        mp_start_d = 1'b0;
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        step       = 1'b0;
        issue      = 1'b0;
        op         = OP_SQ;

        // Outputs are registered, so each issue is decided on the
        // transition into SQ/MUL/CONV.
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    len_d   = mp_count;
                    cnt_d   = '0;
                    state_d = SQ;
                    issue   = 1'b1;
                end
            end
            SQ:  state_d = WAIT_SQ;
            WAIT_SQ: begin
                if (mp_done) begin
                    if (cur_bit) begin
                        state_d = MUL;
                        issue   = 1'b1;
                        op      = OP_MUL;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            MUL: state_d = WAIT_MUL;
            WAIT_MUL: begin
                if (mp_done) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (last) begin
`ifdef FINAL_CONVERT_EN
                    state_d = CONV;
                    issue   = 1'b1;
                    op      = OP_CONV;
`else
                    state_d = DONE;
`endif
                end else begin
                    step    = 1'b1;
                    state_d = SQ;
                    issue   = 1'b1;
                end
            end
`ifdef FINAL_CONVERT_EN
            CONV: state_d = WAIT_CONV;
            WAIT_CONV: begin
                if (mp_done) begin
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            mp_start_d = 1'b1;
            if (cnt_d != '1) begin
                cnt_d = cnt_d + 1'b1;
            end
            a_d = ABITS'(MBAR_ADDR);
            r_d = ABITS'(MBAR_ADDR);
            unique case (op)
                OP_SQ:   b_d = ABITS'(MBAR_ADDR);
                OP_MUL:  b_d = ABITS'(XBAR_ADDR);
                default: b_d = ABITS'(ONE_ADDR);
            endcase
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mp_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mp_start_q <= mp_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            a_q        <= a_d;
            b_q        <= b_d;
            r_q        <= r_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mp_start  = mp_start_q;
    assign mp_a_addr = a_q;
    assign mp_b_addr = b_q;
    assign mp_r_addr = r_q;
    assign mp_len    = len_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Directed bench for modexp_sequencer with a fixed-latency multiplier.
// Ops are decoded from the B address: 2=S, 0=M, 4=C.
module tb_modexp_sequencer;

    localparam int LAT = 2;
`ifdef FINAL_CONVERT_EN
    localparam int DONE_LAT = 1;
`else
    localparam int DONE_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] e = '0;
    logic [4:0]  e_idx = '0;
    logic [4:0]  mp_count = '0;
    logic        mp_done = 1'b0;
    logic        mp_start, busy, done;
    logic [7:0]  mp_a_addr, mp_b_addr, mp_r_addr;
    logic [4:0]  mp_len;
    logic [6:0]  op_count;

    int checks = 0;
    int failures = 0;

    modexp_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .e         (e),
        .e_idx     (e_idx),
        .mp_count  (mp_count),
        .mp_start  (mp_start),
        .mp_a_addr (mp_a_addr),
        .mp_b_addr (mp_b_addr),
        .mp_r_addr (mp_r_addr),
        .mp_len    (mp_len),
        .mp_done   (mp_done),
        .busy      (busy),
        .done      (done),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic chk_str(input string name, input string got,
                           input string exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%s exp=%s", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, " busy"}, busy, 0);
        chk({name, " mp_start"}, mp_start, 0);
        chk({name, " done"}, done, 0);
        chk({name, " addrs"}, {mp_a_addr, mp_b_addr, mp_r_addr}, 0);
        chk({name, " mp_len"}, mp_len, 0);
        chk({name, " op_count"}, op_count, 0);
    endtask

    task automatic run_job(input string name, input logic [31:0] je,
                           input logic [4:0] ji, input logic [4:0] jc,
                           input string exp_ops, input bit glitch,
                           input bit inject, input bit abort);
        string      ops = "";
        int         cd = 0;
        int         done_cnt = 0;
        int         done_cyc = -1;
        int         last_mpd = -100;
        bit         injected = 1'b0;
        bit         fin = 1'b0;
        logic [7:0] last_b = '0;

        @(negedge clk);
        e = je; e_idx = ji; mp_count = jc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, " first_issue"}, mp_start, 1);
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            mp_done = 1'b0;
            start = 1'b0;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk({name, " busy_in_done"}, busy, 1);
                fin = 1'b1;
            end else if (mp_start) begin
                if (mp_a_addr != 8'd2 || mp_r_addr != 8'd2) ops = {ops, "?"};
                else if (mp_b_addr == 8'd2) ops = {ops, "S"};
                else if (mp_b_addr == 8'd0) ops = {ops, "M"};
                else if (mp_b_addr == 8'd4) ops = {ops, "C"};
                else ops = {ops, "?"};
                last_b = mp_b_addr;
                cd = LAT;
                if (glitch) mp_done = 1'b1;
                if (abort && mp_b_addr == 8'd0) begin
                    @(negedge clk);
                    rst = 1'b1;
                    #1;
                    chk_reset({name, " abort"});
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    chk({name, " addr_hold"},
                        {mp_a_addr, mp_b_addr, mp_r_addr},
                        {8'd2, last_b, 8'd2});
                    mp_done = 1'b1;
                    last_mpd = cyc;
                end else if (inject && !injected) begin
                    start = 1'b1;
                    e = 32'hFF; e_idx = 5'd7; mp_count = 5'd31;
                    injected = 1'b1;
                end
            end
        end
        if (!fin) begin
            chk({name, " timeout"}, 1, 0);
        end
        chk_str({name, " ops"}, ops, exp_ops);
        chk({name, " done_count"}, done_cnt, 1);
        chk({name, " done_latency"}, done_cyc - last_mpd, DONE_LAT);
        chk({name, " op_count"}, op_count, exp_ops.len());
        chk({name, " mp_len"}, mp_len, jc);
        @(negedge clk);
        chk({name, " idle_busy"}, busy, 0);
        chk({name, " idle_done"}, done, 0);
        repeat (3) @(negedge clk);
        chk({name, " op_count_hold"}, op_count, exp_ops.len());
    endtask

    typedef struct {
        string       name;
        logic [31:0] e;
        logic [4:0]  idx;
        logic [4:0]  cnt;
        string       ops;
        bit          glitch;
        bit          inject;
        bit          abort;
    } vec_t;

    initial begin
        vec_t  tv[$];
        string all1 = "";
        string top1 = "SM";
        string exp;

        for (int i = 0; i < 32; i++) all1 = {all1, "SM"};
        for (int i = 0; i < 31; i++) top1 = {top1, "S"};

        tv.push_back('{"e1011", 32'hB, 5'd3, 5'd5, "SMSSMSM", 0, 0, 0});
        tv.push_back('{"e1", 32'h1, 5'd0, 5'd9, "SM", 0, 0, 0});
        tv.push_back('{"e0", 32'h0, 5'd2, 5'd3, "SSS", 0, 0, 0});
        tv.push_back('{"inject", 32'hB, 5'd3, 5'd5, "SMSSMSM", 0, 1, 0});
        tv.push_back('{"glitch", 32'hB, 5'd1, 5'd7, "SMSM", 1, 0, 0});
        tv.push_back('{"abort", 32'h1, 5'd0, 5'd4, "", 0, 0, 1});
        tv.push_back('{"after_abort", 32'h5, 5'd2, 5'd2, "SMSSM", 0, 0, 0});
        tv.push_back('{"all_ones", 32'hFFFF_FFFF, 5'd31, 5'd31, all1, 0, 0, 0});
        tv.push_back('{"top_bit", 32'h8000_0000, 5'd31, 5'd1, top1, 1, 0, 0});

        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            exp = tv[i].ops;
`ifdef FINAL_CONVERT_EN
            exp = {exp, "C"};
`endif
            run_job(tv[i].name, tv[i].e, tv[i].idx, tv[i].cnt, exp,
                    tv[i].glitch, tv[i].inject, tv[i].abort);
        end

        // mp_done held high while idle must not start anything.
        @(negedge clk);
        mp_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_mpdone busy", busy, 0);
            chk("idle_mpdone mp_start", mp_start, 0);
        end
        mp_done = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
